// File: rtl/fft_fp_pkg.sv
// Shared types for the FP adder sharing logic: data width, control FSM states
// and the ownership tag carried alongside each in-flight core operation.
package fft_fp_pkg;
   localparam int FP_W      = 32;
   // Sized for the largest supported requester count (8); narrower builds zero-extend.
   localparam int TAG_W_MAX = 3;

   typedef enum logic {
      DRAIN = 1'b0,
      RUN   = 1'b1
   } state_t;

   typedef struct packed {
      logic                 valid;
      logic [TAG_W_MAX-1:0] tag;
   } tag_entry_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward, wrapping,
// and returns the first requester found as a one-hot grant plus its index.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int TAGW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [TAGW-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [TAGW-1:0] idx
);
   logic [TAGW-1:0] cand;

   // Walk from the farthest candidate to the nearest so the nearest wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      cand  = '0;
      for (int i = NREQ; i >= 1; i--) begin
         cand = TAGW'((int'(ptr) + i) % NREQ);
         if (req[cand]) begin
            grant = NREQ'(1) << cand;
            idx   = cand;
         end
      end
   end
endmodule

// File: rtl/fpadd_share_arbiter.sv
// Shares one pipelined FP adder among NREQ requesters with round-robin issue and
// tag-based result return. Optional perf counters under FPADD_ARB_PERF_EN.
module fpadd_share_arbiter
   import fft_fp_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int LAT  = 11,
   parameter int TAGW = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [FP_W*NREQ-1:0] req_a,
   input  logic [FP_W*NREQ-1:0] req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      resp_valid,
   output logic [FP_W-1:0]      resp_data,
   output logic [FP_W-1:0]      add_a,
   output logic [FP_W-1:0]      add_b,
   output logic                 add_nd,
   input  logic [FP_W-1:0]      add_result,
   input  logic                 add_rdy,
   output logic                 err,
`ifdef FPADD_ARB_PERF_EN
   output logic [31:0]          perf_issue,
   output logic [31:0]          perf_contend,
`endif
   output state_t               state_dbg
);
   localparam int CNTW = $clog2(LAT + 2);

   state_t          state, state_nx;
   logic [CNTW-1:0] cnt, cnt_nx;
   logic [TAGW-1:0] rr, gidx;
   logic [NREQ-1:0] grant, tag_onehot;
   logic [FP_W-1:0] op_a, op_b;
   logic            xfer;
   tag_entry_t      iss_ent, tag_out;
   tag_entry_t      tl [LAT];

   rr_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) u_arb (
      .req   (req_valid),
      .ptr   (rr),
      .grant (grant),
      .idx   (gidx)
   );

   // req_valid/req_ready: requester i transfers in any cycle where both bits i are
   // high; req_valid never waits on req_ready. Results have no backpressure.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      req_ready = '0;
      case (state)
         DRAIN: begin
            cnt_nx = cnt - 1'b1;
            if (cnt == CNTW'(1)) state_nx = RUN;
         end
         RUN:     if (!rst) req_ready = grant;
         default: state_nx = DRAIN;
      endcase
      if (rst) begin
         state_nx = DRAIN;
         cnt_nx   = CNTW'(LAT + 1);
      end
   end

   always_ff @(posedge clk) begin
      state <= state_nx;
      cnt   <= cnt_nx;
   end

   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            op_a = req_a[i*FP_W +: FP_W];
            op_b = req_b[i*FP_W +: FP_W];
         end
      end
   end

   assign xfer       = |(req_valid & req_ready);
   assign tag_out    = tl[LAT-1];
   assign tag_onehot = NREQ'(1) << tag_out.tag;
   assign state_dbg  = state;

   // iss_ent travels with add_nd, so the tag line output meets add_rdy LAT cycles later.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr         <= TAGW'(NREQ - 1);
         add_a      <= '0;
         add_b      <= '0;
         add_nd     <= 1'b0;
         iss_ent    <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         err        <= 1'b0;
         for (int i = 0; i < LAT; i++) tl[i] <= '0;
      end else begin
         add_nd      <= xfer;
         iss_ent     <= '{valid: xfer, tag: TAG_W_MAX'(gidx)};
         resp_valid  <= '0;
         if (xfer) begin
            add_a <= op_a;
            add_b <= op_b;
            rr    <= gidx;
         end
         if (state == RUN) begin
            tl[0] <= iss_ent;
            for (int i = 1; i < LAT; i++) tl[i] <= tl[i-1];
            if (add_rdy && tag_out.valid) begin
               resp_valid <= tag_onehot;
               resp_data  <= add_result;
            end else if (add_rdy || tag_out.valid) begin
               err <= 1'b1;
            end
         end else begin
            for (int i = 0; i < LAT; i++) tl[i] <= '0;
         end
      end
   end

`ifdef FPADD_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issue   <= '0;
         perf_contend <= '0;
      end else begin
         if (add_nd && perf_issue != '1) perf_issue <= perf_issue + 1'b1;
         if (state == RUN && $countones(req_valid) >= 2 && perf_contend != '1)
            perf_contend <= perf_contend + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_fpadd_share_arbiter.sv
// Bench for fpadd_share_arbiter: mock LAT-cycle core, directed FP vectors with
// hand-computed sums, scoreboard queue checked by a negedge response monitor.
module tb_fpadd_share_arbiter;
   import fft_fp_pkg::*;

   localparam int NREQ = 4;
   localparam int LAT  = 11;
   localparam int TAGW = 2;
   localparam int W    = NREQ + 32;
   localparam int NV   = 10;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [32*NREQ-1:0]   req_a = '0;
   logic [32*NREQ-1:0]   req_b = '0;
   logic [NREQ-1:0]      req_ready, resp_valid;
   logic [31:0]          resp_data, add_a, add_b, add_result;
   logic                 add_nd, add_rdy, err;
   state_t               state_dbg;
`ifdef FPADD_ARB_PERF_EN
   logic [31:0]          perf_issue, perf_contend;
`endif
   logic                 inj_rdy = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int model_rr = NREQ - 1;
   int cur_vec [NREQ];

   logic [W-1:0] exp_q[$];
   int           exp_cyc_q[$];
   logic [W-1:0] mon_exp;
   int           mon_cyc;

   // Operand pairs and their single-precision sums, worked out by hand.
   logic [31:0] vec_a [NV] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F000000, 32'h40A00000,
                               32'h41200000, 32'hC0000000, 32'h3F800000, 32'h41000000, 32'h40E00000};
   logic [31:0] vec_b [NV] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40400000,
                               32'h40A00000, 32'h40800000, 32'hBF800000, 32'h41000000, 32'h3F800000};
   logic [31:0] vec_s [NV] = '{32'h40400000, 32'h40800000, 32'h40800000, 32'h3F800000, 32'h41000000,
                               32'h41700000, 32'h40000000, 32'h00000000, 32'h41800000, 32'h41000000};

   fpadd_share_arbiter #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_nd     (add_nd),
      .add_result (add_result),
      .add_rdy    (add_rdy),
      .err        (err),
`ifdef FPADD_ARB_PERF_EN
      .perf_issue   (perf_issue),
      .perf_contend (perf_contend),
`endif
      .state_dbg  (state_dbg)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- mock adder core (no reset, LAT-cycle pipe) ----------------
   function automatic logic [31:0] lookup(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < NV; i++) if (vec_a[i] == a && vec_b[i] == b) return vec_s[i];
      return 32'hDEADBEEF;
   endfunction

   logic        pipe_v [LAT] = '{default: 1'b0};
   logic [31:0] pipe_d [LAT] = '{default: 32'h0};
   always @(posedge clk) begin
      pipe_v[0] <= add_nd;
      pipe_d[0] <= lookup(add_a, add_b);
      for (int i = 1; i < LAT; i++) begin
         pipe_v[i] <= pipe_v[i-1];
         pipe_d[i] <= pipe_d[i-1];
      end
   end
   assign add_rdy    = pipe_v[LAT-1] | inj_rdy;
   assign add_result = inj_rdy ? 32'h12345678 : pipe_d[LAT-1];

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_grant(input logic [NREQ-1:0] mask, input int rr);
      for (int i = 1; i <= NREQ; i++) if (mask[(rr + i) % NREQ]) return (rr + i) % NREQ;
      return 0;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (resp_valid != '0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: got resp_valid=%b data=%h, required no response (cycle %0d)",
                     resp_valid, resp_data, cyc);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_cyc = exp_cyc_q.pop_front();
            check("resp", {resp_valid, resp_data}, mon_exp);
            check("resp_latency", cyc, mon_cyc);
         end
      end
   end

   // ---------------- driver tasks (enter/leave 1 unit after a posedge) ----------------
   task automatic set_ops(input int g);
      req_a[g*32 +: 32] = vec_a[cur_vec[g]];
      req_b[g*32 +: 32] = vec_b[cur_vec[g]];
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      req_valid = '0;
      model_rr  = NREQ - 1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_add_ab", {add_a, add_b}, 0);
      check("rst_add_nd", add_nd, 0);
      check("rst_err", err, 0);
      check("rst_state", state_dbg, DRAIN);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // All requesters valid through DRAIN; core mock emits stray results on cycles 2 and 5.
   task automatic drain_check();
      logic [NREQ-1:0] eg;
      for (int i = 0; i < NREQ; i++) set_ops(i);
      req_valid = '1;
      for (int k = 1; k <= LAT + 1; k++) begin
         inj_rdy = (k == 2 || k == 5);
         @(negedge clk);
         check("drain_req_ready", req_ready, 0);
         @(posedge clk); #1;
      end
      inj_rdy = 1'b0;
      @(negedge clk);
      eg = NREQ'(1) << exp_grant('1, model_rr);
      check("run_first_grant", req_ready, eg);
      check("drain_err", err, 0);
      check("run_state", state_dbg, RUN);
      req_valid = '0;
      @(posedge clk); #1;
   endtask

   task automatic burst(input logic [NREQ-1:0] mask, input int ncyc, input bit track);
      int g;
      logic [NREQ-1:0] eg;
      req_valid = mask;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         g  = exp_grant(mask, model_rr);
         eg = NREQ'(1) << g;
         check("grant", req_ready, eg);
         if (track) begin
            exp_q.push_back({eg, vec_s[cur_vec[g]]});
            exp_cyc_q.push_back(cyc + LAT + 2);
         end
         model_rr = g;
         @(posedge clk); #1;
         cur_vec[g] = (cur_vec[g] + NREQ) % NV;
         set_ops(g);
      end
      req_valid = '0;
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 4 * LAT) begin
         @(negedge clk);
         n++;
      end
      check(name, exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < NREQ; i++) cur_vec[i] = i;

      // Reset and DRAIN with stray core results.
      apply_reset();
      drain_check();

      // Fairness: all four valid for eight cycles.
      burst('1, 8, 1'b1);
      wait_empty("burst_drain");

      // Single op from requester 2: 1.0 + 2.0.
      cur_vec[2] = 0;
      set_ops(2);
      burst(4'b0100, 1, 1'b1);
      @(negedge clk);
      check("issue_add_nd", add_nd, 1);
      check("issue_add_a", add_a, 32'h3F800000);
      check("issue_add_b", add_b, 32'h40000000);
      @(posedge clk); #1;
      @(negedge clk);
      check("issue_add_nd_pulse", add_nd, 0);
      @(posedge clk); #1;
      wait_empty("single_drain");

      // Orphan result sets sticky err.
      @(negedge clk);
      check("err_before_orphan", err, 0);
      @(posedge clk); #1;
      inj_rdy = 1'b1;
      @(posedge clk); #1;
      inj_rdy = 1'b0;
      @(negedge clk);
      check("err_orphan", err, 1);
      repeat (5) @(posedge clk);
      #1;
      @(negedge clk);
      check("err_sticky", err, 1);
      @(posedge clk); #1;

      // Reset with five ops in flight: none may come back.
      burst(4'b0001, 5, 1'b0);
      apply_reset();
      drain_check();
      repeat (LAT + 4) @(posedge clk);
      #1;
      burst(4'b1000, 1, 1'b1);
      wait_empty("resume_drain");

`ifdef FPADD_ARB_PERF_EN
      // 3 contended issues then 7 uncontended ones.
      apply_reset();
      drain_check();
      burst(4'b0111, 3, 1'b1);
      burst(4'b0001, 7, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("perf_issue", perf_issue, 10);
      check("perf_contend", perf_contend, 3);
      @(posedge clk); #1;
      wait_empty("perf_drain");
`endif

      check("leftover_expected", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
